// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM port arbiter: FSM state encoding, byte-enable bus
// and the byte-enable rule for RAM requests.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_ARB_IDLE      = 2'd0,
    MEM_ARB_GRANT_IF  = 2'd1,
    MEM_ARB_GRANT_MEM = 2'd2
  } mem_arb_state_e;

  typedef logic [3:0] mem_sel_t;

  localparam mem_sel_t MEM_SEL_ALL = 4'b1111;

  // Reads always fetch the whole word; writes pass the requester's enables.
  function automatic mem_sel_t ram_sel_for(input logic we, input mem_sel_t sel);
    return we ? sel : MEM_SEL_ALL;
  endfunction

endpackage

// File: rtl/mem_arb_slot.sv
// One-deep pending slot: captures a request when ce=1 and the slot is free,
// holds it until the arbiter clears it on the RAM acknowledge.
module mem_arb_slot
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  mem_sel_t          sel,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear,
  output logic              busy,
  output logic              capture,
  output logic              view_we,
  output logic [ADDR_W-1:0] view_addr,
  output mem_sel_t          view_sel,
  output logic [DATA_W-1:0] view_wdata
);

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  mem_sel_t          sel_q;
  logic [DATA_W-1:0] wdata_q;

  assign capture = ce & ~busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      busy    <= 1'b1;
      we_q    <= we;
      addr_q  <= addr;
      sel_q   <= sel;
      wdata_q <= wdata;
    end else if (clear) begin
      busy    <= 1'b0;
    end
  end

  // Held fields while pending, otherwise the request being captured this cycle.
  assign view_we    = busy ? we_q    : we;
  assign view_addr  = busy ? addr_q  : addr;
  assign view_sel   = busy ? sel_q   : sel;
  assign view_wdata = busy ? wdata_q : wdata;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch (IF) and the memory
// stage (MEM). Define MEM_ARB_RR_EN for round-robin between pending reads.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_busy,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_ce,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  mem_sel_t          mem_sel,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output mem_sel_t          ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  // Valid/ready: a port's request transfers in any cycle with ce=1 and busy=0;
  // the RAM side holds ram_req and its fields stable until a one-cycle ram_ack.
  mem_arb_state_e    state;

  logic              if_cap, if_clear, if_view_we;
  logic [ADDR_W-1:0] if_view_addr;
  mem_sel_t          if_view_sel;
  logic [DATA_W-1:0] if_view_wdata;

  logic              mem_cap, mem_clear, mem_view_we;
  logic [ADDR_W-1:0] mem_view_addr;
  mem_sel_t          mem_view_sel;
  logic [DATA_W-1:0] mem_view_wdata;

  logic              if_any, mem_any, go, pick_mem;

  assign if_clear  = (state == MEM_ARB_GRANT_IF)  & ram_ack;
  assign mem_clear = (state == MEM_ARB_GRANT_MEM) & ram_ack;

  mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if_slot (
    .clk        (clk),
    .rst        (rst),
    .ce         (if_ce),
    .we         (1'b0),
    .addr       (if_addr & WORD_MASK),
    .sel        (MEM_SEL_ALL),
    .wdata      ('0),
    .clear      (if_clear),
    .busy       (if_busy),
    .capture    (if_cap),
    .view_we    (if_view_we),
    .view_addr  (if_view_addr),
    .view_sel   (if_view_sel),
    .view_wdata (if_view_wdata)
  );

  mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem_slot (
    .clk        (clk),
    .rst        (rst),
    .ce         (mem_ce),
    .we         (mem_we),
    .addr       (mem_addr),
    .sel        (mem_sel),
    .wdata      (mem_wdata),
    .clear      (mem_clear),
    .busy       (mem_busy),
    .capture    (mem_cap),
    .view_we    (mem_view_we),
    .view_addr  (mem_view_addr),
    .view_sel   (mem_view_sel),
    .view_wdata (mem_view_wdata)
  );

`ifdef MEM_ARB_RR_EN
  logic last_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_mem <= 1'b0;
    end else if (go) begin
      last_mem <= pick_mem;
    end
  end
`endif

  // From IDLE a same-cycle capture can be granted at once; on an ack only
  // requests already held in a slot are eligible.
  always_comb begin
    if_any   = if_busy | if_cap;
    mem_any  = mem_busy | mem_cap;
    go       = 1'b0;
    pick_mem = 1'b0;
    case (state)
      MEM_ARB_IDLE: begin
        go = if_any | mem_any;
`ifdef MEM_ARB_RR_EN
        pick_mem = mem_any & (~if_any | mem_view_we | ~last_mem);
`else
        pick_mem = mem_any;
`endif
      end
      MEM_ARB_GRANT_IF: begin
        go       = ram_ack & mem_busy;
        pick_mem = 1'b1;
      end
      MEM_ARB_GRANT_MEM: begin
        go       = ram_ack & if_busy;
        pick_mem = 1'b0;
      end
      default: begin
        go       = 1'b0;
        pick_mem = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= MEM_ARB_IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_sel   <= '0;
      ram_wdata <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if_done  <= if_clear;
      mem_done <= mem_clear;
      if (if_clear) begin
        if_rdata <= ram_rdata;
      end
      if (mem_clear && !ram_we) begin
        mem_rdata <= ram_rdata;
      end
      if (go) begin
        state     <= pick_mem ? MEM_ARB_GRANT_MEM : MEM_ARB_GRANT_IF;
        ram_req   <= 1'b1;
        ram_we    <= pick_mem ? mem_view_we : if_view_we;
        ram_addr  <= pick_mem ? mem_view_addr : if_view_addr;
        ram_sel   <= pick_mem ? ram_sel_for(mem_view_we, mem_view_sel)
                              : ram_sel_for(if_view_we, if_view_sel);
        ram_wdata <= pick_mem ? mem_view_wdata : if_view_wdata;
      end else if (state != MEM_ARB_IDLE && ram_ack) begin
        state   <= MEM_ARB_IDLE;
        ram_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single/overlapping requests,
// stalled RAM, arbitration order and reset during an outstanding grant.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_ce = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_busy, if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_ce = 1'b0;
  logic              mem_we = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [3:0]        mem_sel = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic              mem_busy, mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              ram_req, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_sel;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ack = 1'b0;
  logic [DATA_W-1:0] ram_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_ce     (if_ce),
    .if_addr   (if_addr),
    .if_busy   (if_busy),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_sel   (mem_sel),
    .mem_wdata (mem_wdata),
    .mem_busy  (mem_busy),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .ram_req   (ram_req),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_sel   (ram_sel),
    .ram_wdata (ram_wdata),
    .ram_ack   (ram_ack),
    .ram_rdata (ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic if_req(input logic [31:0] a);
    if_ce   = 1'b1;
    if_addr = a;
  endtask

  task automatic mem_req(input logic we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] wd);
    mem_ce    = 1'b1;
    mem_we    = we;
    mem_addr  = a;
    mem_sel   = s;
    mem_wdata = wd;
  endtask

  task automatic ack(input logic [31:0] d);
    ram_ack   = 1'b1;
    ram_rdata = d;
  endtask

  task automatic drain();
    int n = 0;
    while ((ram_req || if_busy || mem_busy) && n < 20) begin
      ram_ack = ram_req;
      tick();
      n++;
    end
    ram_ack = 1'b0;
    check("drain_idle", {29'd0, ram_req, if_busy, mem_busy}, 32'd0);
  endtask

  // Both ports captured in the done cycle of a lone MEM read.
  task automatic pair_test(input string tag, input logic second_we, input logic [31:0] exp_first);
    mem_req(1'b0, 32'hC00, 4'hF, 32'h0);
    tick();
    mem_ce = 1'b0;
    ack(32'h0000_0C00);
    tick();
    ram_ack = 1'b0;
    check({tag, "_done"}, {31'd0, mem_done}, 32'd1);
    mem_req(second_we, 32'hC04, 4'hF, 32'h0000_00AB);
    if_req(32'hD00);
    tick();
    mem_ce = 1'b0;
    if_ce  = 1'b0;
    check({tag, "_first"}, ram_addr, exp_first);
    drain();
  endtask

  initial begin
    int seen;
    int n;

    #2 rst = 1'b0;
    ram_ack = 1'b1;
    tick();
    tick();
    ram_ack = 1'b0;
    check("rst_ram_req", {31'd0, ram_req}, 32'd0);
    check("rst_busy", {30'd0, if_busy, mem_busy}, 32'd0);
    check("rst_done", {30'd0, if_done, mem_done}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_ram_fields", {27'd0, ram_we, ram_sel}, 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // single IF read, low address bits ignored
    if_req(32'h103);
    tick();
    if_ce = 1'b0;
    check("t1_req", {31'd0, ram_req}, 32'd1);
    check("t1_addr", ram_addr, 32'h100);
    check("t1_we_sel", {27'd0, ram_we, ram_sel}, 32'h0000_000F);
    check("t1_busy", {31'd0, if_busy}, 32'd1);
    tick();
    ack(32'hDEAD_BEEF);
    check("t1_no_early_done", {31'd0, if_done}, 32'd0);
    tick();
    ram_ack = 1'b0;
    check("t1_done", {31'd0, if_done}, 32'd1);
    check("t1_rdata", if_rdata, 32'hDEAD_BEEF);
    check("t1_busy_clr", {31'd0, if_busy}, 32'd0);
    check("t1_req_clr", {31'd0, ram_req}, 32'd0);
    tick();
    check("t1_done_pulse", {31'd0, if_done}, 32'd0);
    check("t1_rdata_hold", if_rdata, 32'hDEAD_BEEF);

    // IF and MEM write captured together: MEM first, IF with no bubble
    if_req(32'h300);
    mem_req(1'b1, 32'h200, 4'b0011, 32'h1234);
    tick();
    if_ce  = 1'b0;
    mem_ce = 1'b0;
    check("t2_mem_first", ram_addr, 32'h200);
    check("t2_mem_we_sel", {27'd0, ram_we, ram_sel}, 32'h0000_0013);
    check("t2_mem_wdata", ram_wdata, 32'h1234);
    check("t2_both_busy", {30'd0, if_busy, mem_busy}, 32'd3);
    ack(32'h5555_5555);
    tick();
    check("t2_mem_done", {30'd0, if_done, mem_done}, 32'd1);
    check("t2_mem_rdata_kept", mem_rdata, 32'd0);
    check("t2_if_no_bubble", {31'd0, ram_req}, 32'd1);
    check("t2_if_addr", ram_addr, 32'h300);
    check("t2_if_we_sel", {27'd0, ram_we, ram_sel}, 32'h0000_000F);
    ack(32'hCAFE_0001);
    tick();
    ram_ack = 1'b0;
    check("t2_if_done", {30'd0, if_done, mem_done}, 32'd2);
    check("t2_if_rdata", if_rdata, 32'hCAFE_0001);

    // MEM read and IF re-request captured in the if_done cycle
    mem_req(1'b0, 32'h404, 4'b0000, 32'h0);
    if_req(32'h500);
    tick();
    mem_ce = 1'b0;
    if_ce  = 1'b0;
    check("t3_both_queued", {30'd0, if_busy, mem_busy}, 32'd3);
    check("t3_req", {31'd0, ram_req}, 32'd1);
    check("t3_mem_addr", ram_addr, 32'h404);
    check("t3_read_sel", {27'd0, ram_we, ram_sel}, 32'h0000_000F);
    ack(32'h1111_2222);
    tick();
    check("t3_mem_done", {31'd0, mem_done}, 32'd1);
    check("t3_mem_rdata", mem_rdata, 32'h1111_2222);
    check("t3_if_addr", ram_addr, 32'h500);
    ack(32'h3333_4444);
    tick();
    ram_ack = 1'b0;
    check("t3_if_done", {31'd0, if_done}, 32'd1);
    check("t3_if_rdata", if_rdata, 32'h3333_4444);

    // posted write with sel=0 still completes; rdata untouched
    mem_req(1'b1, 32'h900, 4'b0000, 32'h55);
    tick();
    mem_ce = 1'b0;
    check("t4_sel_zero", {27'd0, ram_we, ram_sel}, 32'h0000_0010);
    check("t4_wdata", ram_wdata, 32'h55);
    ack(32'hBAD0_BAD0);
    tick();
    ram_ack = 1'b0;
    check("t4_done", {31'd0, mem_done}, 32'd1);
    check("t4_rdata_hold", mem_rdata, 32'h1111_2222);

    // RAM stalls for 10 cycles; new IF ce is not captured meanwhile
    if_req(32'h700);
    tick();
    if_req(32'h800);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_stall_req", {31'd0, ram_req}, 32'd1);
      check("t5_stall_addr", ram_addr, 32'h700);
      check("t5_stall_busy", {31'd0, if_busy}, 32'd1);
    end
    if_ce = 1'b0;
    ack(32'h77);
    tick();
    ram_ack = 1'b0;
    check("t5_done", {31'd0, if_done}, 32'd1);
    check("t5_rdata", if_rdata, 32'h77);
    tick();
    check("t5_no_capture", {30'd0, ram_req, if_busy}, 32'd0);

    // continuous reads from both ports alternate MEM, IF, MEM, IF
    exp_q = {32'hA00, 32'hB00, 32'hA00, 32'hB00};
    mem_req(1'b0, 32'hA00, 4'hF, 32'h0);
    if_req(32'hB00);
    seen = 0;
    n = 0;
    while (exp_q.size() > 0 && n < 30) begin
      tick();
      n++;
      ram_ack = ram_req;
      if (ram_req) begin
        check("t6_grant_order", ram_addr, exp_q.pop_front());
        seen++;
      end
    end
    check("t6_grants_seen", seen, 32'd4);
    mem_ce = 1'b0;
    if_ce  = 1'b0;
    tick();
    drain();

    // read pair after a MEM grant: the pointer favours IF; a write always wins MEM
`ifdef MEM_ARB_RR_EN
    pair_test("t7_read_pair", 1'b0, 32'hD00);
`else
    pair_test("t7_read_pair", 1'b0, 32'hC04);
`endif
    pair_test("t7_write_pair", 1'b1, 32'hC04);

    // reset while GRANT_MEM waits, then a stray ack after release
    mem_req(1'b0, 32'h600, 4'hF, 32'h0);
    tick();
    mem_ce = 1'b0;
    check("t8_granted", {31'd0, ram_req}, 32'd1);
    tick();
    #2 rst = 1'b0;
    #1;
    check("t8_async_req", {31'd0, ram_req}, 32'd0);
    check("t8_async_busy", {31'd0, mem_busy}, 32'd0);
    check("t8_async_addr", ram_addr, 32'd0);
    check("t8_async_rdata", if_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    ack(32'h99);
    tick();
    ram_ack = 1'b0;
    check("t8_stray_done", {30'd0, if_done, mem_done}, 32'd0);
    check("t8_stray_rdata", mem_rdata, 32'd0);
    tick();
    check("t8_still_idle", {29'd0, ram_req, mem_done, mem_busy}, 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single word-wide external RAM port between the instruction-fetch requester (IF) and the memory-stage requester (MEM). Each requester hands off its access with a one-cycle capture handshake. The arbiter queues at most one access per requester, sequences them onto the RAM request/acknowledge handshake, and returns read data with a one-cycle done pulse. It sits between the pipeline stages and the top-level RAM/bus adapter.

## Interface
- ADDR_W, 32, byte address width (matches `MemAddrBus`)
- DATA_W, 32, data word width (matches `RegBus`)
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_ce  in  1  IF read request
- if_addr  in  ADDR_W  IF word address; bits [1:0] are ignored and driven 0
- if_busy  out  1  IF slot occupied
- if_done  out  1  one-cycle pulse; IF read data valid
- if_rdata  out  DATA_W  IF read data; held until the next IF done
- mem_ce  in  1  MEM request
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  MEM address
- mem_sel  in  4  MEM byte enables for writes; ignored for reads
- mem_wdata  in  DATA_W  MEM write data
- mem_busy  out  1  MEM slot occupied
- mem_done  out  1  one-cycle pulse; MEM access complete
- mem_rdata  out  DATA_W  MEM read data; held until the next MEM done
- ram_req  out  1  RAM request; held until ram_ack
- ram_we  out  1  RAM write
- ram_addr  out  ADDR_W  RAM address
- ram_sel  out  4  RAM byte enables; 4'b1111 for all reads
- ram_wdata  out  DATA_W  RAM write data
- ram_ack  in  1  one-cycle completion pulse from RAM
- ram_rdata  in  DATA_W  RAM read data; valid with ram_ack

## Operation
- Capture: a port accepts a request in any cycle where ce=1 and that port's busy=0.
  - The request fields are latched into that port's pending slot.
  - busy goes to 1 on the next cycle.
  - ce is not sampled while busy=1.
- MEM writes are posted. The requester may drop ce after capture; mem_done still pulses when the write completes.
- FSM states:
  - IDLE: pending slots are examined. If any slot is pending, go to GRANT_IF or GRANT_MEM; the RAM outputs are registered from the winning slot.
  - GRANT_IF / GRANT_MEM: ram_req=1 and the RAM outputs are held stable. On ram_ack, capture ram_rdata into that port's rdata register and clear its slot.
    - If the other slot is pending, move directly to the other GRANT state with no bubble.
    - Otherwise return to IDLE.
- Arbitration:
  - By default MEM has fixed priority over IF.
  - A slot that is captured in the same cycle as an ack is visible to the arbiter only from the next cycle.
- Outputs:
  - done pulses the cycle after ram_ack.
  - busy deasserts in the same cycle as done, so a new request can be captured in the done cycle.
  - rdata is updated only for reads. For writes, rdata keeps its previous value.
- Reset:
  - All outputs go to 0 immediately: ram_req, both busy, both done, both rdata, and all ram_* fields.
  - The FSM goes to IDLE and both slots are cleared.
  - A ram_ack that arrives after reset is released while in IDLE is ignored.
- ram_ack while in IDLE, or while rst is asserted, is ignored.
- mem_sel is passed through unchanged. A write with mem_sel=4'b0000 (misaligned store) still performs a full handshake.

## Timing
- Capture at cycle T → ram_req=1 at T+1 at the earliest.
- ram_ack at cycle A → done=1 and busy=0 at A+1.
- Minimum latency from ce to done is 2 cycles (ack in the same cycle as the first ram_req).
- Back-to-back grants: the cycle after ram_ack, ram_req stays 1 with the other port's fields.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- MEM_ARB_RR_EN defined:
  - IF and MEM alternate under a one-bit last-grant pointer whenever both slots are pending.
  - A pending MEM write still always wins over IF, so a store is visible to a later fetch.
- MEM_ARB_RR_EN undefined: fixed MEM priority and no pointer register.

## Structure
- Add to `defines.v`:
  - the FSM state encodings `MemArbIdle`, `MemArbGrantIf`, `MemArbGrantMem`
  - `MemSelBus` (3:0)
- Existing buses are reused: `MemAddrBus`, `RegBus`.
- One sub-module, `mem_arb_slot`: a capture register holding pending, we, addr, sel and wdata, with a busy output. It is instantiated twice; the IF instance has we and sel tied off.

## Test plan
- IF read of 0x100, RAM acks one cycle after ram_req with 0xDEADBEEF → if_done one cycle after the ack, if_rdata=0xDEADBEEF, if_busy 1→0 in that cycle.
- IF and MEM captured in the same cycle (MEM write 0x200, sel=4'b0011, data 0x1234) → the MEM grant is issued first; the IF grant follows with no idle cycle; the dones are ordered MEM then IF.
- MEM read captured in the if_done cycle while IF re-requests → both are queued; the next granted transaction starts on the following cycle.
- rst asserted while GRANT_MEM is waiting, then a stray ram_ack after release → ram_req and mem_busy go to 0 immediately; the ack is ignored; no done pulse.
- MEM_ARB_RR_EN defined, a stream of MEM reads and IF reads both continuously pending → grants alternate MEM, IF, MEM, IF; with MEM writes instead, MEM is always granted first.
- RAM holds ram_ack low for 10 cycles → the RAM outputs stay stable, busy stays 1, and a new ce on that port is not captured.
